// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, branch flushes, shared-RAM fetch conflicts
// and multi-cycle memory waits with timeout, plus saturating debug counters.
module hazard_ctrl #(
  parameter int unsigned       REG_W    = 4,
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] IMEM_TOP = 16'h7FFF,
  parameter int unsigned       MEM_TMO  = 8,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              idExMemRead,
  input  logic [REG_W-1:0]  idExRd,
  input  logic              idExRegWrite,
  input  logic [REG_W-1:0]  ifIdRs,
  input  logic [REG_W-1:0]  ifIdRt,
  input  logic              ifIdUseRs,
  input  logic              ifIdUseRt,
  input  logic              branchTaken,
  input  logic              exMemAccess,
  input  logic [ADDR_W-1:0] exMemAddr,
  input  logic              memReady,
  output logic              pcWrite,
  output logic              ifIdWrite,
  output logic              ifIdFlush,
  output logic              idExWrite,
  output logic              idExFlush,
  output logic              exMemWrite,
  output logic              memErr,
  output logic [CNT_W-1:0]  stallCnt,
  output logic [CNT_W-1:0]  flushCnt
);

  localparam int unsigned     WC_W     = (MEM_TMO > 2) ? $clog2(MEM_TMO) : 1;
  localparam logic [WC_W-1:0] TMO_LAST = WC_W'(MEM_TMO - 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  waitCnt_q, waitCnt_d;
  logic             memErr_q, memErr_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  logic release_w, freeze, loadUse, structural, brFlush;

  always_comb begin
    release_w  = (state_q == MEM_WAIT) && (waitCnt_q == TMO_LAST);
    freeze     = exMemAccess && !memReady && !release_w;
    loadUse    = idExMemRead && idExRegWrite &&
                 ((ifIdUseRs && (ifIdRs == idExRd)) || (ifIdUseRt && (ifIdRt == idExRd)));
    structural = exMemAccess && (exMemAddr <= IMEM_TOP);
    brFlush    = 1'b0;

    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExWrite  = 1'b1;
    idExFlush  = 1'b0;
    exMemWrite = 1'b1;

    if (RST) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExWrite  = 1'b0;
      exMemWrite = 1'b0;
      ifIdFlush  = 1'b1;
      idExFlush  = 1'b1;
    end else if (freeze) begin
      // Whole pipe holds, so a taken branch in EX stays presented until release.
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExWrite  = 1'b0;
      exMemWrite = 1'b0;
    end else if (branchTaken) begin
      ifIdFlush  = 1'b1;
      idExFlush  = 1'b1;
      brFlush    = 1'b1;
    end else if (loadUse) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExFlush  = 1'b1;
    end else if (structural) begin
      pcWrite    = 1'b0;
      ifIdFlush  = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    memErr_d  = memErr_q;
    unique case (state_q)
      RUN: begin
        if (exMemAccess && !memReady) begin
          state_d   = MEM_WAIT;
          waitCnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (memReady) begin
          state_d = RUN;
        end else if (release_w) begin
          memErr_d = 1'b1;
          state_d  = RUN;
        end else begin
          waitCnt_d = waitCnt_q + WC_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    stallCnt_d = stallCnt_q;
    if (!pcWrite && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + CNT_W'(1);
    flushCnt_d = flushCnt_q;
    if (brFlush && (flushCnt_q != '1)) flushCnt_d = flushCnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= RUN;
      waitCnt_q  <= '0;
      memErr_q   <= 1'b0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      memErr_q   <= memErr_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign memErr   = memErr_q;
  assign stallCnt = stallCnt_q;
  assign flushCnt = flushCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default instance plus a CNT_W=4 instance for counter saturation.
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        idExMemRead, idExRegWrite, ifIdUseRs, ifIdUseRt, branchTaken, exMemAccess, memReady;
  logic [3:0]  idExRd, ifIdRs, ifIdRt;
  logic [15:0] exMemAddr;

  logic        pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memErr;
  logic [15:0] stallCnt, flushCnt;
  logic        s_pcWrite, s_ifIdWrite, s_ifIdFlush, s_idExWrite, s_idExFlush, s_exMemWrite, s_memErr;
  logic [3:0]  s_stallCnt, s_flushCnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite}
  localparam logic [5:0] C_RST  = 6'b001010;
  localparam logic [5:0] C_NORM = 6'b110101;
  localparam logic [5:0] C_LU   = 6'b000111;
  localparam logic [5:0] C_BR   = 6'b111111;
  localparam logic [5:0] C_STR  = 6'b011101;
  localparam logic [5:0] C_FRZ  = 6'b000000;

  logic [5:0] ctrl;
  assign ctrl = {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite};

  always #5 CLK = ~CLK;

  hazard_ctrl u_dut (
    .CLK(CLK), .RST(RST),
    .idExMemRead(idExMemRead), .idExRd(idExRd), .idExRegWrite(idExRegWrite),
    .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .ifIdUseRs(ifIdUseRs), .ifIdUseRt(ifIdUseRt),
    .branchTaken(branchTaken), .exMemAccess(exMemAccess), .exMemAddr(exMemAddr), .memReady(memReady),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush), .idExWrite(idExWrite),
    .idExFlush(idExFlush), .exMemWrite(exMemWrite), .memErr(memErr),
    .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  hazard_ctrl #(.CNT_W(4)) u_small (
    .CLK(CLK), .RST(RST),
    .idExMemRead(idExMemRead), .idExRd(idExRd), .idExRegWrite(idExRegWrite),
    .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .ifIdUseRs(ifIdUseRs), .ifIdUseRt(ifIdUseRt),
    .branchTaken(branchTaken), .exMemAccess(exMemAccess), .exMemAddr(exMemAddr), .memReady(memReady),
    .pcWrite(s_pcWrite), .ifIdWrite(s_ifIdWrite), .ifIdFlush(s_ifIdFlush), .idExWrite(s_idExWrite),
    .idExFlush(s_idExFlush), .exMemWrite(s_exMemWrite), .memErr(s_memErr),
    .stallCnt(s_stallCnt), .flushCnt(s_flushCnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    idExMemRead = 0; idExRegWrite = 0; idExRd = 0; ifIdRs = 0; ifIdRt = 0;
    ifIdUseRs = 0; ifIdUseRt = 0; branchTaken = 0; exMemAccess = 0; exMemAddr = 0; memReady = 0;
  endtask

  task automatic set_loaduse();
    idExMemRead = 1; idExRegWrite = 1; idExRd = 4'd3; ifIdRs = 4'd3; ifIdUseRs = 1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    clear_in();
    RST = 1'b1;
    #3;
    chk("reset_ctrl", 32'(ctrl), 32'(C_RST));
    chk("reset_stall", 32'(stallCnt), 0);
    chk("reset_flush", 32'(flushCnt), 0);
    chk("reset_memerr", 32'(memErr), 0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("idle_ctrl", 32'(ctrl), 32'(C_NORM));
    tick();
    chk("idle_stall", 32'(stallCnt), 0);

    // load-use on Rs: one bubble cycle
    set_loaduse();
    #1 chk("lu_rs_ctrl", 32'(ctrl), 32'(C_LU));
    tick();
    chk("lu_stall1", 32'(stallCnt), 1);
    clear_in();
    #1 chk("lu_after_ctrl", 32'(ctrl), 32'(C_NORM));
    // Rt match only counts when Rt is used; non-writing load is no hazard
    idExMemRead = 1; idExRegWrite = 1; idExRd = 4'd7; ifIdRt = 4'd7; ifIdUseRt = 0; ifIdRs = 4'd2; ifIdUseRs = 1;
    #1 chk("lu_rt_unused", 32'(ctrl), 32'(C_NORM));
    ifIdUseRt = 1;
    #1 chk("lu_rt_used", 32'(ctrl), 32'(C_LU));
    idExRegWrite = 0;
    #1 chk("lu_nowrite", 32'(ctrl), 32'(C_NORM));
    tick();
    chk("lu_stall_hold", 32'(stallCnt), 1);

    // branch overrides load-use
    clear_in();
    set_loaduse();
    branchTaken = 1;
    #1 chk("br_ctrl", 32'(ctrl), 32'(C_BR));
    tick();
    chk("br_flush1", 32'(flushCnt), 1);
    chk("br_stall_same", 32'(stallCnt), 1);

    // structural conflict vs data-RAM addresses
    clear_in();
    exMemAccess = 1; memReady = 1; exMemAddr = 16'h4000;
    #1 chk("str_4000", 32'(ctrl), 32'(C_STR));
    tick();
    chk("str_stall2", 32'(stallCnt), 2);
    exMemAddr = 16'h8000;
    #1 chk("str_8000", 32'(ctrl), 32'(C_NORM));
    tick();
    exMemAddr = 16'h7FFF;
    #1 chk("str_7fff", 32'(ctrl), 32'(C_STR));
    tick();
    chk("str_stall3", 32'(stallCnt), 3);

    // memory wait: 3 frozen cycles, release on 4th with held branch
    exMemAddr = 16'h8000; memReady = 0; branchTaken = 1;
    for (int i = 1; i <= 3; i++) begin
      #1 chk($sformatf("wait_frz%0d", i), 32'(ctrl), 32'(C_FRZ));
      tick();
    end
    chk("wait_stall6", 32'(stallCnt), 6);
    chk("wait_flush_held", 32'(flushCnt), 1);
    memReady = 1;
    #1 chk("wait_release", 32'(ctrl), 32'(C_BR));
    tick();
    chk("wait_flush2", 32'(flushCnt), 2);
    chk("wait_memerr0", 32'(memErr), 0);

    // timeout: 8 frozen cycles, forced release on the 9th
    branchTaken = 0; memReady = 0;
    for (int i = 1; i <= 8; i++) begin
      #1 chk($sformatf("tmo_frz%0d", i), 32'(ctrl), 32'(C_FRZ));
      tick();
    end
    #1 chk("tmo_release", 32'(ctrl), 32'(C_NORM));
    chk("tmo_memerr_pre", 32'(memErr), 0);
    tick();
    chk("tmo_memerr", 32'(memErr), 1);
    chk("tmo_stall14", 32'(stallCnt), 14);
    clear_in();
    tick();
    tick();
    chk("tmo_memerr_sticky", 32'(memErr), 1);

    // async reset in the middle of a wait
    exMemAccess = 1; exMemAddr = 16'h8000; memReady = 0;
    tick();
    tick();
    chk("rst_pre_stall", 32'(stallCnt), 16);
    #2 RST = 1'b1;
    #1 chk("rst_async_ctrl", 32'(ctrl), 32'(C_RST));
    chk("rst_async_stall", 32'(stallCnt), 0);
    chk("rst_async_memerr", 32'(memErr), 0);
    tick();
    chk("rst_held_flush", 32'(flushCnt), 0);
    chk("rst_held_stall", 32'(stallCnt), 0);
    @(negedge CLK);
    memReady = 1;
    RST = 1'b0;
    #1 chk("rst_run_ctrl", 32'(ctrl), 32'(C_NORM));
    memReady = 0;
    #1 chk("rst_run_frz", 32'(ctrl), 32'(C_FRZ));
    tick();
    // from RUN a fresh wait needs the full timeout again
    for (int i = 2; i <= 8; i++) begin
      #1 chk($sformatf("rst_frz%0d", i), 32'(ctrl), 32'(C_FRZ));
      tick();
    end
    #1 chk("rst_tmo_release", 32'(ctrl), 32'(C_NORM));
    tick();
    chk("rst_tmo_stall8", 32'(stallCnt), 8);

    // saturation on the narrow instance
    clear_in();
    set_loaduse();
    for (int i = 0; i < 20; i++) tick();
    chk("sat_big", 32'(stallCnt), 28);
    chk("sat_small", 32'(s_stallCnt), 15);
    chk("sat_small_flush", 32'(s_flushCnt), 0);
    clear_in();
    tick();
    chk("sat_small_hold", 32'(s_stallCnt), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
